vector_lsu: RTL and testbench
=============================

// Module: vector_lsu
// PURPOSE
//  Vector load/store unit downstream of vector_decoder: executes one memory "beat" per decoder cycle_count step.
//  Consumes vlsu_en/load/store/strided; returns vlsu_ready; drives OBI-style data bus; returns load words to vector RF.
//  Unit-stride: one 32b word per beat. Strided: one bus access per element, packed into one RF word per beat.
// PARAMETERS
//  ADDR_W  32  data bus address width
//  DATA_W  32  data bus / vector RF word width (fixed 32: 4 byte lanes)
// PORTS
//  clk             in   1   clock
//  n_reset         in   1   reset, asynchronous, active-low
//  vlsu_en_i       in   1   decoder requests a memory beat (held high for whole instruction)
//  vlsu_load_i     in   1   beat is a load (vle/vlse)
//  vlsu_store_i    in   1   beat is a store (vse/vsse)
//  vlsu_strided_i  in   1   strided addressing; else unit-stride
//  base_addr_i     in   32  rs1 base address (decoder scalar_operand1)
//  stride_i        in   32  rs2 byte stride (decoder scalar_operand2), strided only
//  beat_i          in   2   beat index (decoder cycle_count)
//  vl_i            in   5   vector length, 0..16
//  vsew_i          in   2   element width 0=8b 1=16b 2=32b; 3 treated as 2
//  vs_wdata_i      in   32  store data word from vector RF (vs3)
//  vlsu_ready_o    out  1   beat complete / unit idle; decoder advances cycle_count when high
//  vd_wvalid_o     out  1   load writeback strobe, 1 cycle
//  vd_wdata_o      out  32  load writeback word
//  vd_wbe_o        out  4   writeback byte enables
//  data_req_o      out  1   bus request; held until data_gnt_i
//  data_gnt_i      in   1   bus grant
//  data_addr_o     out  32  bus address
//  data_we_o       out  1   1=write
//  data_be_o       out  4   bus byte enables
//  data_wdata_o    out  32  bus write data
//  data_rvalid_i   in   1   response valid (loads and stores)
//  data_rdata_i    in   32  read data
// BEHAVIOUR
//  Reset: state IDLE, elem counter 0, capture regs 0; all outputs 0 except vlsu_ready_o = ~vlsu_en_i.
//  vlsu_ready_o (comb) = (IDLE & ~vlsu_en_i) | DONE. Must drop same cycle en rises, else decoder over-counts.
//  epw (elements/word) = 4>>vsew (4/2/1); esz bytes = 1<<vsew.
//  Active elems n = clamp(vl_i - beat_i*epw, 0, epw); active byte mask m = low n*esz bytes set.
//  FSM IDLE->REQ: en & (load|store) & n>0; IDLE->DONE: en & (load|store) & n==0 (no bus access, vd_wbe_o=0).
//  REQ: data_req_o=1, addr/we/be/wdata stable until data_gnt_i; on gnt -> WAIT_R.
//  WAIT_R: on data_rvalid_i capture data; if more elements (strided, k<n-1) -> REQ k+1; else -> DONE.
//  DONE (1 cycle): vlsu_ready_o=1; loads assert vd_wvalid_o with vd_wdata_o/vd_wbe_o=m; -> IDLE.
//  Beat-to-beat gap: DONE->IDLE->REQ, i.e. one idle bubble cycle between beats.
//  Unit-stride: addr = base + beat*4; be = m; store wdata = vs_wdata_i; load word taken whole, masked by m.
//  Strided elem k: idx = beat*epw+k; addr = base + idx*stride (mod 2^32, wraps silently);
//   lane = addr[1:0]; be = esz-byte mask << lane; store wdata = element k of vs_wdata_i shifted to lane;
//   load: bytes at lane extracted into element slot k of write word.
//  Addresses must be element-aligned; misaligned strided access: be/data clipped to lane 3, no error raised.
//  Stores: only beat_i word written (decoder issues single beat); vd_wvalid_o never asserted.
//  load & store both high: load has priority. en with neither: stay IDLE, ready=0.
//  en drops mid-beat: finish outstanding req/rvalid, then IDLE; no vd_wvalid_o, no ready pulse.
//  Async reset mid-beat: IDLE immediately; rvalid arriving after reset ignored.
//  Strided elem counter wraps only at epw; RF word accumulator cleared on entering REQ from IDLE.
// TESTING
//  Unit load vsew=0 vl=16 base=0x100, gnt/rvalid immediate -> addrs 0x100,104,108,10C; 4 wvalid, wbe=F each.
//  Unit load vsew=1 vl=3 -> beat0 wbe=F, beat1 wbe=3; bus be 4'h3 on beat1; ready pulses exactly twice.
//  Strided load vsew=0 vl=4 base=0x200 stride=5 -> addrs 200,205,20A,20F; lanes 0,1,2,3 extracted; one wvalid.
//  Store unit vsew=2 vl=1 vs_wdata=0xDEADBEEF -> one req we=1 be=F addr=base; no vd_wvalid; ready 1 cycle.
//  gnt delayed 3 cycles, rvalid 2 more -> req/addr stable throughout; ready low until DONE; vl=0 -> no req.
//  Assert n_reset in WAIT_R -> IDLE, all outputs 0; late rvalid after reset causes no writeback.

Source files
------------

// File: rtl/vector_lsu_if.sv
// OBI-style data bus between the vector LSU (master) and the data memory port (slave).
interface vector_lsu_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/vector_lsu.sv
// Vector load/store unit: one memory beat per decoder cycle_count step, unit-stride
// (one word per beat) or strided (one bus access per element packed into one RF word).
module vector_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              vlsu_en_i,
  input  logic              vlsu_load_i,
  input  logic              vlsu_store_i,
  input  logic              vlsu_strided_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [1:0]        beat_i,
  input  logic [4:0]        vl_i,
  input  logic [1:0]        vsew_i,
  input  logic [DATA_W-1:0] vs_wdata_i,
  output logic              vlsu_ready_o,
  output logic              vd_wvalid_o,
  output logic [DATA_W-1:0] vd_wdata_o,
  output logic [3:0]        vd_wbe_o,
  vector_lsu_if.master      data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        elem, elem_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic              op_load, op_load_nxt;
  logic              abort, abort_nxt;

  logic [1:0]        sew;
  logic [2:0]        epw, esz, n;
  logic [4:0]        first, rem;
  logic [3:0]        nbytes, m, esz_mask, idx, elem_prod;
  logic [ADDR_W-1:0] addr_cur;
  logic [1:0]        lane;
  logic [4:0]        lane_sh, elem_sh;
  logic [DATA_W-1:0] emask, byte_mask, rd_elem;
  logic              last;

  // Beat geometry; decoder holds all operands stable for the whole beat.
  always_comb begin
    sew   = (vsew_i == 2'd3) ? 2'd2 : vsew_i;
    epw   = 3'd4 >> sew;
    esz   = 3'd1 << sew;
    first = {3'b000, beat_i} * {2'b00, epw};
    rem   = vl_i - first;
    if (vl_i <= first)             n = '0;
    else if (rem >= {2'b00, epw})  n = epw;
    else                           n = rem[2:0];
    nbytes = {1'b0, n} * {1'b0, esz};
    case (nbytes)
      4'd0:    m = 4'h0;
      4'd1:    m = 4'h1;
      4'd2:    m = 4'h3;
      4'd3:    m = 4'h7;
      default: m = 4'hF;
    endcase
    case (sew)
      2'd0:    begin esz_mask = 4'h1; emask = DATA_W'(8'hFF);   end
      2'd1:    begin esz_mask = 4'h3; emask = DATA_W'(16'hFFFF); end
      default: begin esz_mask = 4'hF; emask = '1;                end
    endcase
    idx = first[3:0] + {2'b00, elem};
    if (vlsu_strided_i) addr_cur = base_addr_i + stride_i * ADDR_W'(idx);
    else                addr_cur = base_addr_i + ADDR_W'({beat_i, 2'b00});
    lane      = vlsu_strided_i ? addr_cur[1:0] : 2'b00;
    lane_sh   = {lane, 3'b000};
    elem_prod = {2'b00, elem} * {1'b0, esz};
    elem_sh   = {elem_prod[1:0], 3'b000};
    byte_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    rd_elem   = ((data.rdata >> lane_sh) & emask) << elem_sh;
    last      = ~vlsu_strided_i | (({1'b0, elem} + 3'd1) >= n);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      elem    <= '0;
      acc     <= '0;
      op_load <= 1'b0;
      abort   <= 1'b0;
    end else begin
      state   <= state_nxt;
      elem    <= elem_nxt;
      acc     <= acc_nxt;
      op_load <= op_load_nxt;
      abort   <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    elem_nxt     = elem;
    acc_nxt      = acc;
    op_load_nxt  = op_load;
    abort_nxt    = abort;
    vlsu_ready_o = 1'b0;
    vd_wvalid_o  = 1'b0;
    vd_wdata_o   = '0;
    vd_wbe_o     = '0;
    data.req     = 1'b0;
    data.addr    = '0;
    data.we      = 1'b0;
    data.be      = '0;
    data.wdata   = '0;
    case (state)
      IDLE: begin
        vlsu_ready_o = ~vlsu_en_i;
        abort_nxt    = 1'b0;
        if (vlsu_en_i && (vlsu_load_i || vlsu_store_i)) begin
          op_load_nxt = vlsu_load_i;
          elem_nxt    = '0;
          acc_nxt     = '0;
          state_nxt   = (n == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        data.req  = 1'b1;
        data.addr = addr_cur;
        data.we   = ~op_load;
        if (vlsu_strided_i) begin
          data.be    = esz_mask << lane;
          data.wdata = ((vs_wdata_i >> elem_sh) & emask) << lane_sh;
        end else begin
          data.be    = m;
          data.wdata = vs_wdata_i;
        end
        if (!vlsu_en_i) abort_nxt = 1'b1;
        if (data.gnt) state_nxt = WAIT_R;
      end
      WAIT_R: begin
        if (!vlsu_en_i) abort_nxt = 1'b1;
        if (data.rvalid) begin
          if (op_load) acc_nxt = vlsu_strided_i ? (acc | rd_elem) : (data.rdata & byte_mask);
          // A dropped enable still drains the outstanding response but skips DONE.
          if (abort || !vlsu_en_i) state_nxt = IDLE;
          else if (!last) begin
            elem_nxt  = elem + 2'd1;
            state_nxt = REQ;
          end else state_nxt = DONE;
        end
      end
      DONE: begin
        vlsu_ready_o = 1'b1;
        vd_wvalid_o  = op_load;
        vd_wdata_o   = op_load ? acc : '0;
        vd_wbe_o     = op_load ? m : '0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Scoreboard bench for vector_lsu: driver pushes expected bus/writeback records, a
// negedge monitor pops and compares them; a bus slave model answers with delays.
module tb_vector_lsu;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
  } wb_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        en = 1'b0, ld = 1'b0, st = 1'b0, sd = 1'b0;
  logic [31:0] base = '0, stride = '0, vs_wdata = '0;
  logic [1:0]  beat = '0, vsew = '0;
  logic [4:0]  vl = '0;
  logic        ready, vd_wvalid;
  logic [31:0] vd_wdata;
  logic [3:0]  vd_wbe;

  vector_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  vector_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .n_reset(n_reset),
    .vlsu_en_i(en), .vlsu_load_i(ld), .vlsu_store_i(st), .vlsu_strided_i(sd),
    .base_addr_i(base), .stride_i(stride), .beat_i(beat), .vl_i(vl), .vsew_i(vsew),
    .vs_wdata_i(vs_wdata), .vlsu_ready_o(ready), .vd_wvalid_o(vd_wvalid),
    .vd_wdata_o(vd_wdata), .vd_wbe_o(vd_wbe), .data(bus)
  );

  always #5 clk = ~clk;

  int   errors = 0, checks = 0;
  int   ready_cnt = 0, wv_total = 0;
  bus_t exp_bus[$];
  wb_t  exp_wb[$];

  // Memory image: byte at address A holds A[7:0] + 0x11.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b0;
    b0 = {a[7:2], 2'b00} + 8'h11;
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  // Bus slave
  int          gnt_delay = 0, rv_delay = 0, gw = 0, rw = 0;
  bit          rpend = 1'b0;
  logic [31:0] ra;
  logic        rwe;
  initial begin
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    forever begin
      @(posedge clk); #2;
      bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
      if (rpend) begin
        if (rw == 0) begin
          bus.rvalid = 1'b1;
          bus.rdata  = rwe ? 32'h0 : mem_word(ra);
          rpend      = 1'b0;
        end else rw--;
      end
      if (bus.req && !rpend) begin
        if (gw < gnt_delay) gw++;
        else begin
          bus.gnt = 1'b1; gw = 0; rpend = 1'b1; rw = rv_delay;
          ra = bus.addr; rwe = bus.we;
        end
      end
    end
  end

  // Monitor / scoreboard
  logic req_q = 1'b0, gnt_q = 1'b0;
  bus_t prev;
  always @(negedge clk) begin
    if (en && ready) ready_cnt++;
    if (bus.req && req_q && !gnt_q) begin
      checks++;
      if (bus.addr !== prev.addr || bus.we !== prev.we || bus.be !== prev.be || bus.wdata !== prev.wdata) begin
        errors++;
        $display("FAIL req_stable got addr=%h be=%h now addr=%h be=%h", prev.addr, prev.be, bus.addr, bus.be);
      end
    end
    if (bus.req && bus.gnt) begin
      checks++;
      if (exp_bus.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected got addr=%h we=%b be=%h", bus.addr, bus.we, bus.be);
      end else begin
        bus_t e;
        e = exp_bus.pop_front();
        if (bus.addr !== e.addr || bus.we !== e.we || bus.be !== e.be || (e.we && bus.wdata !== e.wdata)) begin
          errors++;
          $display("FAIL bus_txn got addr=%h we=%b be=%h wd=%h exp addr=%h we=%b be=%h wd=%h",
                   bus.addr, bus.we, bus.be, bus.wdata, e.addr, e.we, e.be, e.wdata);
        end
      end
    end
    if (vd_wvalid) begin
      wv_total++;
      checks++;
      if (exp_wb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got data=%h be=%h", vd_wdata, vd_wbe);
      end else begin
        wb_t w;
        w = exp_wb.pop_front();
        if (vd_wdata !== w.data || vd_wbe !== w.be) begin
          errors++;
          $display("FAIL wb got data=%h be=%h exp data=%h be=%h", vd_wdata, vd_wbe, w.data, w.be);
        end
      end
    end
    req_q = bus.req; gnt_q = bus.gnt;
    prev.addr = bus.addr; prev.we = bus.we; prev.be = bus.be; prev.wdata = bus.wdata;
  end

  task automatic push_bus(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    bus_t e;
    e.addr = a; e.we = w; e.be = b; e.wdata = d;
    exp_bus.push_back(e);
  endtask

  task automatic push_wb(input logic [31:0] d, input logic [3:0] b);
    wb_t w;
    w.data = d; w.be = b;
    exp_wb.push_back(w);
  endtask

  // Runs one instruction of nbeats beats; exp_lat (if nonzero) is the first beat's
  // en-to-ready latency in cycles.
  task automatic run_instr(input logic l, input logic s, input logic strd,
                           input logic [31:0] b, input logic [31:0] strd_b,
                           input logic [4:0] v, input logic [1:0] w,
                           input logic [31:0] wd, input int nbeats, input int exp_lat);
    int lat;
    bit got;
    @(posedge clk); #1;
    ld = l; st = s; sd = strd; base = b; stride = strd_b; vl = v; vsew = w; vs_wdata = wd;
    beat = '0; en = 1'b1; ready_cnt = 0;
    for (int i = 0; i < nbeats; i++) begin
      beat = i[1:0];
      lat = 0; got = 1'b0;
      while (!got && lat < 200) begin
        @(negedge clk); lat++;
        if (ready) got = 1'b1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL ready_timeout beat=%0d got none within %0d cycles", i, lat);
      end else if (i == 0 && exp_lat != 0) begin
        checks++;
        if (lat != exp_lat) begin
          errors++;
          $display("FAIL latency got=%0d exp=%0d", lat, exp_lat);
        end
      end
      @(posedge clk); #1;
    end
    en = 1'b0; ld = 1'b0; st = 1'b0; sd = 1'b0;
    checks++;
    if (ready_cnt != nbeats) begin
      errors++;
      $display("FAIL ready_pulses got=%0d exp=%0d", ready_cnt, nbeats);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int wv0, n_bad;
    bit got;
    #1000000;
    $display("FAIL global_timeout got stuck exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wv0, n_bad;
    bit got;
    // Reset state
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, vd_wvalid, vd_wdata, vd_wbe, bus.req, bus.addr, bus.we, bus.be, bus.wdata} !== {1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b req=%b wv=%b addr=%h exp ready=1 rest 0", ready, bus.req, vd_wvalid, bus.addr);
    end
    @(posedge clk); #1 n_reset = 1'b1;
    repeat (2) @(posedge clk);

    // Unit load, vsew=8b, vl=16: four full words
    push_bus(32'h100, 1'b0, 4'hF, 32'h0); push_wb(32'h14131211, 4'hF);
    push_bus(32'h104, 1'b0, 4'hF, 32'h0); push_wb(32'h18171615, 4'hF);
    push_bus(32'h108, 1'b0, 4'hF, 32'h0); push_wb(32'h1C1B1A19, 4'hF);
    push_bus(32'h10C, 1'b0, 4'hF, 32'h0); push_wb(32'h201F1E1D, 4'hF);
    run_instr(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 5'd16, 2'd0, 32'h0, 4, 4);

    // Unit load, vsew=16b, vl=3: tail beat masked to two bytes
    push_bus(32'h140, 1'b0, 4'hF, 32'h0); push_wb(32'h54535251, 4'hF);
    push_bus(32'h144, 1'b0, 4'h3, 32'h0); push_wb(32'h00005655, 4'h3);
    run_instr(1'b1, 1'b0, 1'b0, 32'h140, 32'h0, 5'd3, 2'd1, 32'h0, 2, 4);

    // Strided load, vsew=8b, stride 5: lanes 0..3 packed into one word
    push_bus(32'h200, 1'b0, 4'h1, 32'h0);
    push_bus(32'h205, 1'b0, 4'h2, 32'h0);
    push_bus(32'h20A, 1'b0, 4'h4, 32'h0);
    push_bus(32'h20F, 1'b0, 4'h8, 32'h0);
    push_wb(32'h201B1611, 4'hF);
    run_instr(1'b1, 1'b0, 1'b1, 32'h200, 32'd5, 5'd4, 2'd0, 32'h0, 1, 10);

    // Strided load, vsew=32b, address wraps past 2^32
    push_bus(32'hFFFFFFF0, 1'b0, 4'hF, 32'h0); push_wb(32'h04030201, 4'hF);
    push_bus(32'h00000000, 1'b0, 4'hF, 32'h0); push_wb(32'h14131211, 4'hF);
    run_instr(1'b1, 1'b0, 1'b1, 32'hFFFFFFF0, 32'h10, 5'd2, 2'd2, 32'h0, 2, 4);

    // Unit store, vsew=32b, vl=1: no writeback
    push_bus(32'h300, 1'b1, 4'hF, 32'hDEADBEEF);
    run_instr(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 5'd1, 2'd2, 32'hDEADBEEF, 1, 4);

    // Strided store, vsew=16b, stride 3: second element misaligned, clipped to lane 3
    push_bus(32'h500, 1'b1, 4'h3, 32'h0000CCDD);
    push_bus(32'h503, 1'b1, 4'h8, 32'hBB000000);
    run_instr(1'b0, 1'b1, 1'b1, 32'h500, 32'd3, 5'd2, 2'd1, 32'hAABBCCDD, 1, 6);

    // Delayed grant and response; request must hold steady
    gnt_delay = 3; rv_delay = 2;
    push_bus(32'h400, 1'b0, 4'hF, 32'h0); push_wb(32'h14131211, 4'hF);
    run_instr(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 5'd1, 2'd2, 32'h0, 1, 9);
    gnt_delay = 0; rv_delay = 0;

    // vl=0: no bus access, empty writeback
    push_wb(32'h0, 4'h0);
    run_instr(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 5'd0, 2'd2, 32'h0, 1, 2);

    // Enable without load/store: stays idle, ready low
    @(posedge clk); #1 en = 1'b1; vl = 5'd4;
    n_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready || bus.req) n_bad++;
    end
    checks++;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL no_op_idle got bad_cycles=%0d exp=0", n_bad);
    end
    @(posedge clk); #1 en = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while waiting for the response; late rvalid must be ignored
    rv_delay = 6;
    push_bus(32'h600, 1'b0, 4'hF, 32'h0);
    @(posedge clk); #1;
    ld = 1'b1; sd = 1'b0; base = 32'h600; vl = 5'd1; vsew = 2'd2; beat = '0; en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.req && bus.gnt) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout got none exp grant");
    end
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    checks++;
    if ({ready, vd_wvalid, vd_wdata, vd_wbe, bus.req, bus.addr, bus.we, bus.be, bus.wdata} !== {1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_beat got ready=%b req=%b wv=%b addr=%h exp all 0", ready, bus.req, vd_wvalid, bus.addr);
    end
    en = 1'b0; ld = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", ready);
    end
    @(posedge clk); #1 n_reset = 1'b1;
    wv0 = wv_total;
    repeat (12) @(posedge clk);
    checks++;
    if (wv_total != wv0) begin
      errors++;
      $display("FAIL late_rvalid_wb got=%0d exp=0", wv_total - wv0);
    end
    rv_delay = 0;

    checks++;
    if (exp_bus.size() != 0) begin
      errors++;
      $display("FAIL bus_leftover got=%0d exp=0", exp_bus.size());
    end
    checks++;
    if (exp_wb.size() != 0) begin
      errors++;
      $display("FAIL wb_leftover got=%0d exp=0", exp_wb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
